sdp_ram_clr: RTL and testbench

Parametrised simple dual-port RAM with one clock, write port A and read port B. It adds per-byte write enables, a selectable 1- or 2-cycle read latency with a `valid_b` strobe, and a hardware clear engine that fills the array with `INIT_VALUE` after reset or on request. It replaces fixed-constant preloaded RAMs in the coefficient and buffer stores of the crypto datapath. Software-visible state comes out of reset in a known value without `initial` blocks.

---
 rtl/sdp_ram_clr.sv | 136 +++++++++++++
 tb/tb_sdp_ram_clr.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_clr.sv
// Simple dual-port RAM with byte enables, 1/2-cycle reads and a clear engine.
// Define SDP_RAM_BYPASS_EN for write-first collisions (read-first otherwise).
module sdp_ram_clr #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0,
  localparam int ADDR_W = $clog2(MEM_DEPTH),
  localparam int BE_W = MEM_WIDTH / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 en_a,
  input  logic                 write_en_a,
  input  logic [BE_W-1:0]      byte_en_a,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [MEM_WIDTH-1:0] data_in_a,
  input  logic                 en_b,
  input  logic [ADDR_W-1:0]    addr_b,
  output logic [MEM_WIDTH-1:0] data_out_b,
  output logic                 valid_b
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic in_range_a, in_range_b;
  logic wr_a, rd_req;
  logic [MEM_WIDTH-1:0] rd_word;
  logic v1;
  logic [MEM_WIDTH-1:0] d1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_nx = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy       = (state == CLEAR);
  assign in_range_a = ({1'b0, addr_a} < DEPTH_X);
  assign in_range_b = ({1'b0, addr_b} < DEPTH_X);
  assign wr_a       = !busy && en_a && write_en_a && in_range_a;
  assign rd_req     = !busy && en_b;

  // Array deliberately has no reset; the clear engine defines it.
  always_ff @(posedge clock) begin
    if (busy) begin
      mem[cnt] <= INIT_VALUE;
    end else if (wr_a) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byte_en_a[i]) mem[addr_a][8*i +: 8] <= data_in_a[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = INIT_VALUE;
    if (in_range_b) rd_word = mem[addr_b];
`ifdef SDP_RAM_BYPASS_EN
    if (wr_a && (addr_a == addr_b)) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byte_en_a[i]) rd_word[8*i +: 8] = data_in_a[8*i +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_req;
      if (rd_req) d1 <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic v2;
    logic [MEM_WIDTH-1:0] d2;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign valid_b    = v2;
    assign data_out_b = d2;
  end else begin : g_lat1
    assign valid_b    = v1;
    assign data_out_b = d1;
  end

endmodule

// File: tb/tb_sdp_ram_clr.sv
// Scoreboard bench for sdp_ram_clr: two instances, latency 1 (depth 16)
// and latency 2 (depth 12, non power of two).
module tb_sdp_ram_clr;

  localparam logic [31:0] INIT_A = 32'hDEADBEEF;
  localparam logic [31:0] INIT_B = 32'h0BADF00D;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int passed = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic        a_rst, a_clr, a_busy, a_en_a, a_we, a_en_b, a_valid;
  logic [3:0]  a_be, a_addr_a, a_addr_b;
  logic [31:0] a_din, a_dout;

  logic        b_rst, b_clr, b_busy, b_en_a, b_we, b_en_b, b_valid;
  logic [3:0]  b_be, b_addr_a, b_addr_b;
  logic [31:0] b_din, b_dout;

  sdp_ram_clr #(
    .MEM_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(1), .INIT_VALUE(INIT_A)
  ) u_a (
    .clock(clk), .reset(a_rst), .clear_req(a_clr), .busy(a_busy),
    .en_a(a_en_a), .write_en_a(a_we), .byte_en_a(a_be),
    .addr_a(a_addr_a), .data_in_a(a_din),
    .en_b(a_en_b), .addr_b(a_addr_b),
    .data_out_b(a_dout), .valid_b(a_valid)
  );

  sdp_ram_clr #(
    .MEM_WIDTH(32), .MEM_DEPTH(12), .READ_LATENCY(2), .INIT_VALUE(INIT_B)
  ) u_b (
    .clock(clk), .reset(b_rst), .clear_req(b_clr), .busy(b_busy),
    .en_a(b_en_a), .write_en_a(b_we), .byte_en_a(b_be),
    .addr_a(b_addr_a), .data_in_a(b_din),
    .en_b(b_en_b), .addr_b(b_addr_b),
    .data_out_b(b_dout), .valid_b(b_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL a_spurious_valid: valid_b=1 data %h, required none",
                 a_dout);
      end else begin
        e = qa.pop_front();
        chk("a_read_data", a_dout, e.d);
        chk("a_read_cycle", cyc, e.c);
      end
    end
    if (b_valid) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL b_spurious_valid: valid_b=1 data %h, required none",
                 b_dout);
      end else begin
        e = qb.pop_front();
        chk("b_read_data", b_dout, e.d);
        chk("b_read_cycle", cyc, e.c);
      end
    end
  end

  task automatic write_a(input logic [3:0] ad, input logic [31:0] d,
                         input logic [3:0] be);
    a_en_a = 1; a_we = 1; a_addr_a = ad; a_din = d; a_be = be;
    @(posedge clk); #1;
    a_en_a = 0; a_we = 0;
  endtask

  task automatic read_a(input logic [3:0] ad, input logic [31:0] exp);
    a_en_b = 1; a_addr_b = ad;
    qa.push_back('{exp, cyc + 1});
    @(posedge clk); #1;
    a_en_b = 0;
  endtask

  task automatic write_b(input logic [3:0] ad, input logic [31:0] d,
                         input logic [3:0] be);
    b_en_a = 1; b_we = 1; b_addr_a = ad; b_din = d; b_be = be;
    @(posedge clk); #1;
    b_en_a = 0; b_we = 0;
  endtask

  task automatic read_b(input logic [3:0] ad, input logic [31:0] exp);
    b_en_b = 1; b_addr_b = ad;
    qb.push_back('{exp, cyc + 2});
    @(posedge clk); #1;
    b_en_b = 0;
  endtask

  task automatic busy_len_a(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_busy) n++;
      else break;
    end
  endtask

  task automatic busy_len_b(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b_busy) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    a_rst = 1; a_clr = 0; a_en_a = 0; a_we = 0; a_en_b = 0;
    a_be = 0; a_addr_a = 0; a_addr_b = 0; a_din = 0;
    b_rst = 1; b_clr = 0; b_en_a = 0; b_we = 0; b_en_b = 0;
    b_be = 0; b_addr_a = 0; b_addr_b = 0; b_din = 0;

    @(negedge clk);
    chk("a_rst_busy", 32'(a_busy), 1);
    chk("a_rst_valid", 32'(a_valid), 0);
    chk("a_rst_dout", a_dout, 0);
    chk("b_rst_busy", 32'(b_busy), 1);
    chk("b_rst_dout", b_dout, 0);

    // power-up clear, then every location reads the init word
    @(posedge clk); #1;
    a_rst = 0;
    busy_len_a(n);
    chk("a_clear_len_reset", n, 16);
    for (int i = 0; i < 16; i++) read_a(4'(i), INIT_A);

    // byte-enable merge; an all-zero mask must not write
    write_a(3, 32'h11223344, 4'b1111);
    write_a(3, 32'hAABBCCDD, 4'b0101);
    write_a(3, 32'hFFFFFFFF, 4'b0000);
    read_a(3, 32'h11BB33DD);

    // same-address collision
    a_en_a = 1; a_we = 1; a_be = 4'b1111; a_addr_a = 5; a_din = 32'h0000CAFE;
    a_en_b = 1; a_addr_b = 5;
`ifdef SDP_RAM_BYPASS_EN
    qa.push_back('{32'h0000CAFE, cyc + 1});
`else
    qa.push_back('{INIT_A, cyc + 1});
`endif
    @(posedge clk); #1;
    a_en_a = 0; a_we = 0; a_en_b = 0;
    read_a(5, 32'h0000CAFE);

    // clear request; a repeat request and reads during clear are dropped
    write_a(7, 32'h00000001, 4'b1111);
    a_clr = 1;
    @(posedge clk); #1;
    a_clr = 0;
    fork
      busy_len_a(n);
      begin
        repeat (4) @(posedge clk);
        #1 a_clr = 1; a_en_b = 1; a_addr_b = 7;
        @(posedge clk); #1;
        a_clr = 0; a_en_b = 0;
      end
    join
    chk("a_clear_len_req", n, 16);
    read_a(7, INIT_A);
    read_a(3, INIT_A);

    // clear plus write together, then reset mid-clear
    a_clr = 1; a_en_a = 1; a_we = 1; a_be = 4'b1111;
    a_addr_a = 2; a_din = 32'h12345678;
    @(posedge clk); #1;
    a_clr = 0; a_en_a = 0; a_we = 0;
    a_en_b = 1; a_addr_b = 2;
    repeat (7) @(posedge clk);
    #1 a_rst = 1; a_en_b = 0;
    @(negedge clk);
    chk("a_midrst_busy", 32'(a_busy), 1);
    chk("a_midrst_dout", a_dout, 0);
    @(posedge clk); #1;
    a_rst = 0;
    busy_len_a(n);
    chk("a_clear_len_midrst", n, 16);
    read_a(2, INIT_A);

    // latency-2 instance, depth 12
    b_rst = 0;
    busy_len_b(n);
    chk("b_clear_len_reset", n, 12);
    write_b(0, 32'd5, 4'b1111);
    write_b(1, 32'd6, 4'b1111);
    write_b(2, 32'd7, 4'b1111);
    write_b(11, 32'h600D0011, 4'b1111);
    write_b(14, 32'hFFFFFFFF, 4'b1111);
    read_b(14, INIT_B);
    read_b(11, 32'h600D0011);
    read_b(13, INIT_B);
    read_b(0, 32'd5);
    read_b(1, 32'd6);
    read_b(2, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b_hold_dout", b_dout, 32'd7);
    chk("b_hold_valid", 32'(b_valid), 0);

    // write one cycle after a read must not affect it
    read_b(0, 32'd5);
    write_b(0, 32'd9, 4'b1111);
    read_b(0, 32'd9);

    // partial-mask collision
    b_en_a = 1; b_we = 1; b_be = 4'b0011; b_addr_a = 4; b_din = 32'h0000CAFE;
    b_en_b = 1; b_addr_b = 4;
`ifdef SDP_RAM_BYPASS_EN
    qb.push_back('{32'h0BADCAFE, cyc + 2});
`else
    qb.push_back('{INIT_B, cyc + 2});
`endif
    @(posedge clk); #1;
    b_en_a = 0; b_we = 0; b_en_b = 0;
    read_b(4, 32'h0BADCAFE);
    repeat (3) @(posedge clk);
    #1;

    // reset discards a read in flight
    b_en_b = 1; b_addr_b = 1;
    @(posedge clk); #1;
    b_en_b = 0; b_rst = 1;
    @(negedge clk);
    chk("b_inflight_valid", 32'(b_valid), 0);
    @(posedge clk); #1;
    b_rst = 0;
    busy_len_b(n);
    chk("b_clear_len_midrst", n, 12);
    read_b(1, INIT_B);

    repeat (5) @(posedge clk);
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
